uart_rx_8n1: RTL and testbench

8N1 UART receive-only block, the receive-side counterpart of the 8N1 transmitter in the UART adder design. Oversamples the asynchronous `rx` line, validates the start bit, assembles 8 data bits LSB first, and checks the stop bit. Holds each received byte in an output register with a valid/acknowledge handshake, and reports framing and overrun errors to the consuming logic (e.g. the adder datapath).

---
 rtl/uart_rx_8n1_if.sv | 32 +++
 rtl/uart_rx_8n1.sv | 157 +++++++++++++++
 tb/tb_uart_rx_8n1.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_8n1_if.sv
// Receive-side bundle for uart_rx_8n1: serial input, received byte,
// valid/acknowledge handshake and status flags.
// master: the receiver (drives byte/status); slave: the line driver and consumer.
interface uart_rx_8n1_if;
    logic       rx;
    logic [7:0] rxbyte;
    logic       rxvalid;
    logic       rxack;
    logic       rxbusy;
    logic       framing_err;
    logic       overrun;

    modport master (
        input  rx,
        input  rxack,
        output rxbyte,
        output rxvalid,
        output rxbusy,
        output framing_err,
        output overrun
    );

    modport slave (
        output rx,
        output rxack,
        input  rxbyte,
        input  rxvalid,
        input  rxbusy,
        input  framing_err,
        input  overrun
    );
endinterface

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with oversampled start validation, LSB-first data
// assembly, stop-bit check and a valid/ack output register.
// Optional macro UART_RX_MAJORITY_EN: every sample becomes the 2-of-3
// majority of the synchronized line over the sample cycle and the two
// cycles before it.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line idle, waiting for synchronized rx low
// START | counting to mid start bit, confirming it is still low
// DATA  | sampling 8 data bits at mid-bit, LSB first
// STOP  | sampling stop bit, completing the frame
// BREAK | stop bit was low; wait for the line to return high
module uart_rx_8n1 #(
    parameter int OVERSAMPLE = 16
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_8n1_if.master  bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t        state;
    logic          rx_m;
    logic          rx_s;
    logic          sample;
    logic [CW-1:0] cnt;
    logic [2:0]    bitidx;
    logic [7:0]    shreg;
    logic [7:0]    rxbyte_q;
    logic          rxvalid_q;
    logic          framing_err_q;
    logic          overrun_q;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= bus.rx;
            rx_s <= rx_m;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] rx_hist;

    // Keep the two previous synchronized samples for the majority vote.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_hist <= 2'b11;
        end else begin
            rx_hist <= {rx_hist[0], rx_s};
        end
    end

    assign sample = (rx_s & rx_hist[0]) | (rx_s & rx_hist[1]) | (rx_hist[0] & rx_hist[1]);
`else
    assign sample = rx_s;
`endif

    // Frame FSM plus the output register and valid/ack handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bitidx        <= 3'd0;
            shreg         <= 8'h00;
            rxbyte_q      <= 8'h00;
            rxvalid_q     <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            // Consumer acknowledge; a completion below in the same cycle overrides it.
            if (bus.rxack && rxvalid_q) begin
                rxvalid_q <= 1'b0;
                overrun_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end

                START: begin
                    if (cnt == HALF_M1) begin
                        if (!sample) begin
                            state  <= DATA;
                            cnt    <= '0;
                            bitidx <= 3'd0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == FULL_M1) begin
                        shreg <= {sample, shreg[7:1]};
                        cnt   <= '0;
                        if (bitidx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bitidx <= bitidx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == FULL_M1) begin
                        rxbyte_q      <= shreg;
                        rxvalid_q     <= 1'b1;
                        framing_err_q <= !sample;
                        // An ack landing on the completion cycle consumes the old byte.
                        overrun_q     <= bus.rxack ? 1'b0 : (overrun_q | rxvalid_q);
                        cnt           <= '0;
                        state         <= sample ? IDLE : BREAK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rxbyte      = rxbyte_q;
    assign bus.rxvalid     = rxvalid_q;
    assign bus.framing_err = framing_err_q;
    assign bus.overrun     = overrun_q;
    assign bus.rxbusy      = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed and randomized bench for uart_rx_8n1 (OVERSAMPLE = 16).
// The reference model works per frame: it samples the driven line
// waveform at the nominal mid-bit points and applies the handshake rules.
`timescale 1ns/1ps
module tb_uart_rx_8n1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_8n1_if bus ();

    uart_rx_8n1 #(.OVERSAMPLE(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nvec  = 0;
    int nfail = 0;

    logic       line_q [0:255];
    int         line_len;
    logic [7:0] m_byte;
    logic       m_valid, m_ferr, m_ovr;
    int         rise_edge;
    logic       busy_mid;

    logic [7:0] r_d;
    int         r_sl, r_pol, r_gap;

    // Value the receiver should see for pin-cycle k (2-flop lag already folded in).
    function automatic logic samp(int k);
`ifdef UART_RX_MAJORITY_EN
        return (line_q[k] & line_q[k-1]) | (line_q[k] & line_q[k-2]) | (line_q[k-1] & line_q[k-2]);
`else
        return line_q[k];
`endif
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(string tag);
        chk({tag, " rxbyte"},      {24'd0, bus.rxbyte},      {24'd0, m_byte});
        chk({tag, " rxvalid"},     {31'd0, bus.rxvalid},     {31'd0, m_valid});
        chk({tag, " framing_err"}, {31'd0, bus.framing_err}, {31'd0, m_ferr});
        chk({tag, " overrun"},     {31'd0, bus.overrun},     {31'd0, m_ovr});
        chk({tag, " rxbusy"},      {31'd0, bus.rxbusy},      32'd0);
    endtask

    task automatic model_reset();
        m_byte = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic model_ack();
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    // Frame completes: data bit n sits at pin cycle 24+16n, stop at 152.
    task automatic model_complete(logic ack);
        logic [7:0] b;
        for (int n = 0; n < 8; n++) b[n] = samp(24 + 16 * n);
        m_ovr   = ack ? 1'b0 : (m_ovr | m_valid);
        m_byte  = b;
        m_valid = 1'b1;
        m_ferr  = !samp(152);
    endtask

    task automatic build_line(logic [7:0] d, int stop_len, logic stop_v, int glitch_at);
        line_len = 144 + stop_len;
        for (int k = 0; k < line_len; k++) begin
            int   bt;
            logic v;
            bt = k / 16;
            if (bt == 0)      v = 1'b0;
            else if (bt <= 8) v = d[bt-1];
            else              v = stop_v;
            if (k == glitch_at) v = !v;
            line_q[k] = v;
        end
    endtask

    // Drive line_q one pin cycle per clock; edge k+1 closes pin cycle k.
    task automatic play(int ack_at, int rst_at);
        rise_edge = -1;
        busy_mid  = 1'b0;
        for (int k = 0; k < line_len; k++) begin
            logic prev_v;
            prev_v    = bus.rxvalid;
            bus.rx    = line_q[k];
            bus.rxack = (k == ack_at);
            rst       = (k == rst_at);
            @(posedge clk);
            if (k == rst_at) begin
                #1;
                rst       = 1'b0;
                bus.rx    = 1'b1;
                bus.rxack = 1'b0;
                model_reset();
                return;
            end
            if (k + 1 == 155)    model_complete(k == ack_at);
            else if (k == ack_at) model_ack();
            #1;
            bus.rxack = 1'b0;
            if (!prev_v && bus.rxvalid && rise_edge < 0) rise_edge = k + 1;
            if (k == 80) busy_mid = bus.rxbusy;
        end
        bus.rx = 1'b1;
    endtask

    task automatic frame(logic [7:0] d, int stop_len, logic stop_v, int glitch_at, int ack_at, int rst_at);
        build_line(d, stop_len, stop_v, glitch_at);
        play(ack_at, rst_at);
    endtask

    task automatic idle(int n);
        bus.rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ack_pulse();
        bus.rxack = 1'b1;
        @(posedge clk);
        model_ack();
        #1;
        bus.rxack = 1'b0;
    endtask

    initial begin
        bus.rx    = 1'b1;
        bus.rxack = 1'b0;
        rst       = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all("reset");

        // Single frame, latency and busy.
        frame(8'hA5, 16, 1'b1, -1, -1, -1);
        chk("a5 latency", rise_edge, 32'd155);
        chk("a5 busy_mid", {31'd0, busy_mid}, 32'd1);
        chk("a5 byte", {24'd0, bus.rxbyte}, 32'hA5);
        idle(4);
        chk_all("a5");
        ack_pulse();

        // Back-to-back with short stop bits, ack in between.
        frame(8'h3C, 15, 1'b1, -1, -1, -1);
        chk("b2b first", {24'd0, bus.rxbyte}, 32'h3C);
        frame(8'hC3, 15, 1'b1, -1, 20, -1);
        chk("b2b second", {24'd0, bus.rxbyte}, 32'hC3);
        idle(4);
        chk_all("b2b");
        ack_pulse();

        // Framing error, long break, recovery.
        frame(8'h55, 56, 1'b0, -1, 165, -1);
        chk("brk ferr", {31'd0, bus.framing_err}, 32'd1);
        chk("brk byte", {24'd0, bus.rxbyte}, 32'h55);
        idle(30);
        chk_all("brk hold");
        frame(8'h01, 16, 1'b1, -1, -1, -1);
        idle(4);
        chk_all("post brk");
        chk("post brk ferr", {31'd0, bus.framing_err}, 32'd0);
        ack_pulse();

        // Overrun, then ack clears.
        frame(8'h11, 16, 1'b1, -1, -1, -1);
        idle(3);
        frame(8'h22, 16, 1'b1, -1, -1, -1);
        idle(4);
        chk_all("ovr");
        chk("ovr set", {31'd0, bus.overrun}, 32'd1);
        ack_pulse();
        chk_all("ovr ack");

        // Ack on the completion cycle: no overrun.
        frame(8'h11, 16, 1'b1, -1, -1, -1);
        idle(3);
        frame(8'h22, 16, 1'b1, -1, 154, -1);
        idle(4);
        chk_all("ack same");
        chk("ack same ovr", {31'd0, bus.overrun}, 32'd0);
        ack_pulse();

        // False start: 6 low cycles.
        bus.rx = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("false busy", {31'd0, bus.rxbusy}, 32'd1);
        idle(20);
        chk_all("false start");

        // Reset in the middle of a data bit.
        frame(8'h7E, 16, 1'b1, -1, -1, -1);
        idle(2);
        frame(8'h7E, 16, 1'b1, -1, -1, 60);
        chk_all("mid rst");
        idle(10);
        frame(8'h7E, 16, 1'b1, -1, -1, -1);
        idle(4);
        chk_all("after rst");
        chk("after rst byte", {24'd0, bus.rxbyte}, 32'h7E);
        ack_pulse();

        // One-cycle glitch landing on the bit-3 sample.
        frame(8'h00, 16, 1'b1, 72, -1, -1);
        idle(4);
        chk_all("glitch");
`ifdef UART_RX_MAJORITY_EN
        chk("glitch byte", {24'd0, bus.rxbyte}, 32'h00);
`else
        chk("glitch byte", {24'd0, bus.rxbyte}, 32'h08);
`endif
        ack_pulse();

        // Randomized frames with random ack placement.
        for (int i = 0; i < 10; i++) begin
            r_d   = 8'($urandom_range(0, 255));
            r_sl  = $urandom_range(15, 16);
            r_pol = $urandom_range(0, 2);
            r_gap = $urandom_range(0, 6);
            frame(r_d, r_sl, 1'b1, -1, (r_pol == 1) ? 50 : ((r_pol == 2) ? 154 : -1), -1);
            chk_all("rand");
            idle(r_gap);
            if ($urandom_range(0, 1) == 1) ack_pulse();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
